uart_tx_frame: RTL and testbench

- UART transmitter; the counterpart to the RX edge/bit counter path in the UART block.
- Accepts a parallel byte on a valid/busy handshake, then serialises it on tx_out, one bit per clk cycle.
- clk is the TX bit clock, already divided from the reference clock by the clock divider.
- Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit. Feeds the system's serial output pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_parity_calc.sv | 18 +
 rtl/uart_tx_frame.sv | 136 +++++++++++++
 tb/tb_uart_tx_frame.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and line/parity constants.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Parity bit for a TX payload: even parity makes the total count of ones even,
// odd parity makes it odd.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  logic w_xor;

  assign w_xor    = ^i_data;
  assign o_parity = (i_par_typ == PAR_ODD) ? ~w_xor : w_xor;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts a byte when idle and sends start, data (LSB first),
// optional parity and stop bits, one bit per clk cycle.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy,
  output tx_state_e             o_dbg_state
);

  // Handshake: a payload is taken on a rising edge where data_valid=1 and
  // busy=0; while busy=1 data_valid is ignored, so the source holds it until
  // busy rises. Nothing is queued.

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_busy;

  tx_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_par_en_nxt;
  logic                  w_par_bit_nxt;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;
  logic                  w_parity;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data   (p_data),
    .i_par_typ(par_typ),
    .o_parity (w_parity)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= TX_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= STOP_BIT;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_par_en  <= w_par_en_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_par_en_nxt  = r_par_en;
    w_par_bit_nxt = r_par_bit;
    w_tx_nxt      = STOP_BIT;
    w_busy_nxt    = 1'b0;

    case (r_state)
      TX_IDLE: begin
        if (data_valid) begin
          w_state_nxt   = TX_START;
          w_shift_nxt   = p_data;
          w_cnt_nxt     = '0;
          w_par_en_nxt  = par_en;
          w_par_bit_nxt = w_parity;
        end
      end
      TX_START: begin
        w_state_nxt = TX_DATA;
        w_cnt_nxt   = '0;
      end
      TX_DATA: begin
        w_shift_nxt = r_shift >> 1;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = r_par_en ? TX_PARITY : TX_STOP;
          w_cnt_nxt   = '0;
        end
      end
      TX_PARITY: w_state_nxt = TX_STOP;
      TX_STOP:   w_state_nxt = TX_IDLE;
      default:   w_state_nxt = TX_IDLE;
    endcase

    // Line level is decoded from the next state so the pin comes straight off a flop.
    case (w_state_nxt)
      TX_START: begin
        w_tx_nxt   = START_BIT;
        w_busy_nxt = 1'b1;
      end
      TX_DATA: begin
        w_tx_nxt   = w_shift_nxt[0];
        w_busy_nxt = 1'b1;
      end
      TX_PARITY: begin
        w_tx_nxt   = w_par_bit_nxt;
        w_busy_nxt = 1'b1;
      end
      TX_STOP: begin
        w_tx_nxt   = STOP_BIT;
        w_busy_nxt = 1'b1;
      end
      default: begin
        w_tx_nxt   = STOP_BIT;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign tx_out      = r_tx;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8-bit and a 5-bit instance, directed frames,
// expected line bits queued by the driver and consumed by per-instance monitors.
module tb_uart_tx_frame;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;

  initial forever #5 clk = ~clk;

  // ---------------- DUT A (DATA_WIDTH=8) ----------------
  logic [7:0] a_data     = '0;
  logic       a_valid    = 1'b0;
  logic       a_par_en   = 1'b0;
  logic       a_par_typ  = 1'b0;
  logic       a_tx;
  logic       a_busy;
  tx_state_e  a_state;

  uart_tx_frame #(.DATA_WIDTH(8)) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .p_data     (a_data),
    .data_valid (a_valid),
    .par_en     (a_par_en),
    .par_typ    (a_par_typ),
    .tx_out     (a_tx),
    .busy       (a_busy),
    .o_dbg_state(a_state)
  );

  // ---------------- DUT B (DATA_WIDTH=5) ----------------
  logic [4:0] b_data     = '0;
  logic       b_valid    = 1'b0;
  logic       b_par_en   = 1'b0;
  logic       b_par_typ  = 1'b0;
  logic       b_tx;
  logic       b_busy;
  tx_state_e  b_state;

  uart_tx_frame #(.DATA_WIDTH(5)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .p_data     (b_data),
    .data_valid (b_valid),
    .par_en     (b_par_en),
    .par_typ    (b_par_typ),
    .tx_out     (b_tx),
    .busy       (b_busy),
    .o_dbg_state(b_state)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [0:0] a_exp_q[$];
  logic [0:0] b_exp_q[$];
  int         a_len_q[$];
  int         b_len_q[$];
  bit         a_abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event at %0t", name, $time);
  endtask

  // ---------------- monitors ----------------
  int   a_run = 0;
  logic a_prev_busy = 1'b0;

  always @(negedge clk) begin
    if (a_busy) begin
      a_run++;
      if (a_exp_q.size() == 0) flag_fail("a_unexpected_bit");
      else check("a_tx_bit", 32'(a_tx), 32'(a_exp_q.pop_front()));
    end else begin
      check("a_idle_line", 32'(a_tx), 32'(1));
      if (a_prev_busy) begin
        if (a_len_q.size() > 0) check("a_busy_len", a_run, a_len_q.pop_front());
        else if (a_abort) a_abort = 1'b0;
        else flag_fail("a_unexpected_frame");
        a_run = 0;
      end
    end
    a_prev_busy = a_busy;
  end

  int   b_run = 0;
  logic b_prev_busy = 1'b0;

  always @(negedge clk) begin
    if (b_busy) begin
      b_run++;
      if (b_exp_q.size() == 0) flag_fail("b_unexpected_bit");
      else check("b_tx_bit", 32'(b_tx), 32'(b_exp_q.pop_front()));
    end else begin
      check("b_idle_line", 32'(b_tx), 32'(1));
      if (b_prev_busy) begin
        if (b_len_q.size() > 0) check("b_busy_len", b_run, b_len_q.pop_front());
        else flag_fail("b_unexpected_frame");
        b_run = 0;
      end
    end
    b_prev_busy = b_busy;
  end

  // ---------------- driver tasks ----------------
  // bits holds the frame as written on paper: bits[n-1] is the first bit on the line.
  task automatic push_frame(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) a_exp_q.push_back(bits[n-1-i]);
      else          b_exp_q.push_back(bits[n-1-i]);
    end
    if (sel == 0) a_len_q.push_back(n);
    else          b_len_q.push_back(n);
  endtask

  task automatic wait_busy(input int sel, input logic lvl);
    int n;
    logic cur;
    n = 0;
    cur = (sel == 0) ? a_busy : b_busy;
    while (cur !== lvl && n < 200) begin
      @(posedge clk); #1;
      n++;
      cur = (sel == 0) ? a_busy : b_busy;
    end
    if (cur !== lvl) flag_fail("wait_busy_timeout");
  endtask

  task automatic send_a(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [15:0] bits, input int n);
    wait_busy(0, 1'b0);
    a_data = d; a_par_en = pe; a_par_typ = pt; a_valid = 1'b1;
    push_frame(0, bits, n);
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [4:0] d, input logic pe, input logic pt,
                        input logic [15:0] bits, input int n);
    wait_busy(1, 1'b0);
    b_data = d; b_par_en = pe; b_par_typ = pt; b_valid = 1'b1;
    push_frame(1, bits, n);
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2 rst = 1'b0;
    #1;
    check("a_reset_tx",    32'(a_tx),    32'(1));
    check("a_reset_busy",  32'(a_busy),  32'(0));
    check("a_reset_state", 32'(a_state), 32'(TX_IDLE));
    check("b_reset_tx",    32'(b_tx),    32'(1));
    check("b_reset_busy",  32'(b_busy),  32'(0));
    @(negedge clk); #2 rst = 1'b1;

    // idle 20 cycles with data_valid low
    repeat (20) @(posedge clk);
    #1;
    check("a_idle_after_20", 32'(a_busy), 32'(0));

    // 0xA5 even parity, then odd parity
    send_a(8'hA5, 1'b1, PAR_EVEN, 16'b01010010101, 11);
    send_a(8'hA5, 1'b1, PAR_ODD,  16'b01010010111, 11);

    // 0x00 without parity; a data_valid pulse mid-frame must be ignored
    send_a(8'h00, 1'b0, PAR_EVEN, 16'b0000000001, 10);
    repeat (3) @(posedge clk);
    #1;
    a_data = 8'hFF; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;

    // data_valid held: 0x3C, payload changed to 0xFF mid-frame
    wait_busy(0, 1'b0);
    a_data = 8'h3C; a_par_en = 1'b0; a_par_typ = PAR_EVEN; a_valid = 1'b1;
    push_frame(0, 16'b0001111001, 10);
    push_frame(0, 16'b0111111111, 10);
    wait_busy(0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    a_data = 8'hFF;
    wait_busy(0, 1'b0);
    @(posedge clk); #1;
    check("a_one_idle_gap", 32'(a_busy), 32'(1));
    a_valid = 1'b0;
    wait_busy(0, 1'b0);

    // reset during data bit 4 of 0x55
    send_a(8'h55, 1'b0, PAR_EVEN, 16'b0101010101, 10);
    repeat (5) @(posedge clk);
    #3;
    a_abort = 1'b1;
    a_exp_q.delete();
    a_len_q.delete();
    rst = 1'b0;
    #1;
    check("a_midreset_tx",    32'(a_tx),    32'(1));
    check("a_midreset_busy",  32'(a_busy),  32'(0));
    check("a_midreset_state", 32'(a_state), 32'(TX_IDLE));
    @(negedge clk); #2 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("a_idle_after_reset", 32'(a_busy), 32'(0));
    send_a(8'h55, 1'b1, PAR_ODD, 16'b01010101011, 11);

    // 5-bit instance: 0x13 even parity
    send_b(5'h13, 1'b1, PAR_EVEN, 16'b01100111, 8);

    wait_busy(0, 1'b0);
    wait_busy(1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("a_exp_q_drained", a_exp_q.size(), 0);
    check("a_len_q_drained", a_len_q.size(), 0);
    check("b_exp_q_drained", b_exp_q.size(), 0);
    check("b_len_q_drained", b_len_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
